// File: rtl/tqvp_alonso_rsa_ctrl.sv
// Left-to-right square-and-multiply sequencer: computes plain^exp mod M by
// issuing Montgomery multiplications to an external multiplier (start/done).
module tqvp_alonso_rsa_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] plain_text,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  input  logic [WIDTH-1:0] mont_const,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  output logic [WIDTH-1:0] mm_mod,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_result,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_TOP = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LD_X   = 3'd1,
    ST_LD_ONE = 3'd2,
    ST_SQR    = 3'd3,
    ST_MUL    = 3'd4,
    ST_CONV   = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  state_t state_r, state_s;
  logic [WIDTH-1:0] plain_r, plain_s, exp_r, exp_s, mod_r, mod_s, mc_r, mc_s;
  logic [WIDTH-1:0] xbar_r, xbar_s, acc_r, acc_s, result_r, result_s;
  logic [WIDTH-1:0] mm_a_r, mm_a_s, mm_b_r, mm_b_s, mm_mod_r, mm_mod_s;
  logic [BW-1:0]    bit_r, bit_s;
  logic             done_r, done_s, busy_r, busy_s, mm_start_r, mm_start_s;
  logic             launch_s, wait_done_s, last_bit_s;

  // Operand pair {A, B} for the multiplication launched on entering a state.
  function automatic logic [2*WIDTH-1:0] mm_operands(input state_t st,
      input logic [WIDTH-1:0] pt, input logic [WIDTH-1:0] mc,
      input logic [WIDTH-1:0] acc, input logic [WIDTH-1:0] xb);
    logic [2*WIDTH-1:0] ops;
    case (st)
      ST_LD_X:   ops = {pt, mc};
      ST_LD_ONE: ops = {ONE, mc};
      ST_SQR:    ops = {acc, acc};
      ST_MUL:    ops = {acc, xb};
      ST_CONV:   ops = {acc, ONE};
      default:   ops = {(2*WIDTH){1'b0}};
    endcase
    return ops;
  endfunction

  // Next-state, datapath capture and registered-output computation.
  always_comb begin
    state_s    = state_r;
    plain_s    = plain_r;
    exp_s      = exp_r;
    mod_s      = mod_r;
    mc_s       = mc_r;
    xbar_s     = xbar_r;
    acc_s      = acc_r;
    bit_s      = bit_r;
    result_s   = result_r;
    done_s     = done_r;
    mm_a_s     = mm_a_r;
    mm_b_s     = mm_b_r;
    mm_mod_s   = mm_mod_r;
    mm_start_s = 1'b0;
    launch_s   = 1'b0;
    // a completion during the issue cycle belongs to nothing we launched
    wait_done_s = mm_done & ~mm_start_r;
    last_bit_s  = (bit_r == BIT_ZERO);
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_s = ST_IDLE;
          done_s  = 1'b0;
        end else if (start) begin
          plain_s  = plain_text;
          exp_s    = exponent;
          mod_s    = modulus;
          mc_s     = mont_const;
          done_s   = 1'b0;
          state_s  = ST_LD_X;
          launch_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_LD_X, ST_LD_ONE, ST_SQR, ST_MUL, ST_CONV: begin
        if (stop) begin
          state_s = ST_IDLE;
        end else if (wait_done_s) begin
          launch_s = 1'b1;
          case (state_r)
            ST_LD_X: begin
              xbar_s  = mm_result;
              state_s = ST_LD_ONE;
            end
            ST_LD_ONE: begin
              acc_s   = mm_result;
              bit_s   = BIT_TOP;
              state_s = ST_SQR;
            end
            ST_SQR: begin
              acc_s = mm_result;
              if (exp_r[bit_r]) begin
                state_s = ST_MUL;
              end else if (last_bit_s) begin
                state_s = ST_CONV;
              end else begin
                bit_s   = bit_r - BIT_ONE;
                state_s = ST_SQR;
              end
            end
            ST_MUL: begin
              acc_s = mm_result;
              if (last_bit_s) begin
                state_s = ST_CONV;
              end else begin
                bit_s   = bit_r - BIT_ONE;
                state_s = ST_SQR;
              end
            end
            ST_CONV: begin
              result_s = mm_result;
              done_s   = 1'b1;
              state_s  = ST_DONE;
              launch_s = 1'b0;
            end
            default: begin
              state_s  = ST_IDLE;
              launch_s = 1'b0;
            end
          endcase
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE) && (state_s != ST_DONE);
    if (launch_s) begin
      mm_start_s       = 1'b1;
      {mm_a_s, mm_b_s} = mm_operands(state_s, plain_s, mc_s, acc_s, xbar_s);
      mm_mod_s         = mod_s;
    end else begin
      mm_start_s = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      plain_r    <= {WIDTH{1'b0}};
      exp_r      <= {WIDTH{1'b0}};
      mod_r      <= {WIDTH{1'b0}};
      mc_r       <= {WIDTH{1'b0}};
      xbar_r     <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      mm_a_r     <= {WIDTH{1'b0}};
      mm_b_r     <= {WIDTH{1'b0}};
      mm_mod_r   <= {WIDTH{1'b0}};
      bit_r      <= BIT_ZERO;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      mm_start_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      plain_r    <= plain_s;
      exp_r      <= exp_s;
      mod_r      <= mod_s;
      mc_r       <= mc_s;
      xbar_r     <= xbar_s;
      acc_r      <= acc_s;
      result_r   <= result_s;
      mm_a_r     <= mm_a_s;
      mm_b_r     <= mm_b_s;
      mm_mod_r   <= mm_mod_s;
      bit_r      <= bit_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
      mm_start_r <= mm_start_s;
    end
  end

  assign mm_start = mm_start_r;
  assign mm_a     = mm_a_r;
  assign mm_b     = mm_b_r;
  assign mm_mod   = mm_mod_r;
  assign result   = result_r;
  assign done     = done_r;
  assign busy     = busy_r;
endmodule

// File: tb/tb_tqvp_alonso_rsa_ctrl.sv
// Bench for tqvp_alonso_rsa_ctrl: behavioural Montgomery multiplier (L=3)
// plus a scoreboard of directly computed modular exponentiation results.
module tb_tqvp_alonso_rsa_ctrl;
  localparam int W = 8;
  localparam int L = 3;
  localparam int M = 187;
  localparam int MC = 86;

  logic         clk = 1'b0;
  logic         rst, start, stop, mm_start, mm_done, done, busy;
  logic [W-1:0] plain_text, exponent, modulus, mont_const;
  logic [W-1:0] mm_a, mm_b, mm_mod, mm_result, result;

  int checks = 0;
  int errors = 0;
  int mm_count = 0;
  int mm_cnt_down = 0;
  logic [W-1:0] op_a, op_b, op_m, last_mod_seen;
  logic [W-1:0] last_result;
  logic [W-1:0] exp_q[$];

  tqvp_alonso_rsa_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .plain_text(plain_text), .exponent(exponent), .modulus(modulus),
    .mont_const(mont_const), .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_mod(mm_mod), .mm_done(mm_done), .mm_result(mm_result),
    .result(result), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mont(input int a, input int b, input int m);
    longint t;
    t = longint'(a) * longint'(b);
    for (int i = 0; i < W; i++) begin
      if (t % 2 == 1) t = t + m;
      t = t / 2;
    end
    if (t >= m) t = t - m;
    return W'(t);
  endfunction

  function automatic int modexp(input int b, input int e, input int m);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % m;
    return int'(r % m);
  endfunction

  // Montgomery multiplier model: mm_done L cycles after each mm_start.
  initial begin
    mm_done = 1'b0;
    mm_result = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (rst) begin
        mm_cnt_down = 0;
      end else begin
        if (mm_cnt_down > 0) begin
          mm_cnt_down--;
          if (mm_cnt_down == 0) begin
            mm_done = 1'b1;
            mm_result = mont(int'(op_a), int'(op_b), int'(op_m));
          end
        end
        if (mm_start) begin
          mm_count++;
          op_a = mm_a;
          op_b = mm_b;
          op_m = mm_mod;
          last_mod_seen = mm_mod;
          mm_cnt_down = L;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string name, input int p, input int e,
                        input int mid_start, input int mid_plain);
    int base, cyc, nops;
    logic [W-1:0] want;
    plain_text = W'(p);
    exponent   = W'(e);
    modulus    = W'(M);
    mont_const = W'(MC);
    nops = 3 + W + $countones(W'(e));
    base = mm_count;
    start = 1'b1;
    exp_q.push_back(W'(modexp(p, e, M)));
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
      start = (cyc == mid_start) ? 1'b1 : 1'b0;
      if (mid_plain >= 0 && cyc == 5) plain_text = W'(mid_plain);
    end
    start = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, cyc);
    end else begin
      checks += 4;
      if (result !== want) begin
        errors++;
        $display("FAIL %s result: got %0d, required %0d", name, result, want);
      end
      if (mm_count - base != nops) begin
        errors++;
        $display("FAIL %s mm_count: got %0d, required %0d", name, mm_count - base, nops);
      end
      if (cyc != nops * (L + 1)) begin
        errors++;
        $display("FAIL %s latency: got %0d, required %0d", name, cyc, nops * (L + 1));
      end
      if (busy !== 1'b0 || last_mod_seen !== W'(M)) begin
        errors++;
        $display("FAIL %s busy/mod: busy=%b mod=%0d, required 0/%0d", name, busy, last_mod_seen, M);
      end
      last_result = want;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    plain_text = '0; exponent = '0; modulus = '0; mont_const = '0;
    tick();
    tick();
    checks++;
    if ({mm_start, mm_a, mm_b, mm_mod, result, done, busy} !== '0) begin
      errors++;
      $display("FAIL reset: mm_start=%b a=%0d b=%0d mod=%0d result=%0d done=%b busy=%b, required all 0",
               mm_start, mm_a, mm_b, mm_mod, result, done, busy);
    end
    rst = 1'b0;
    last_result = '0;
    tick();
  endtask

  task automatic test_encrypt();
    run_op("encrypt", 88, 7, -1, -1);
  endtask

  task automatic test_decrypt();
    run_op("decrypt", 11, 23, -1, -1);
  endtask

  task automatic test_exp_zero();
    run_op("exp_zero", 88, 0, 10, -1);
  endtask

  task automatic test_stop();
    int base, n;
    base = mm_count;
    plain_text = 8'd88; exponent = 8'd7; modulus = W'(M); mont_const = W'(MC);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mm_count < base + 5 && n < 100) begin
      tick();
      n++;
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== last_result || mm_start !== 1'b0) begin
      errors++;
      $display("FAIL stop: busy=%b done=%b result=%0d mm_start=%b, required 0/0/%0d/0",
               busy, done, result, mm_start, last_result);
    end
    repeat (8) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== last_result || mm_count != base + 5) begin
      errors++;
      $display("FAIL stop_late_done: busy=%b done=%b result=%0d issues=%0d, required 0/0/%0d/5",
               busy, done, result, mm_count - base, last_result);
    end
    run_op("after_stop", 88, 7, -1, -1);
  endtask

  task automatic test_snapshot();
    int base;
    run_op("snapshot", 88, 7, -1, 5);
    base = mm_count;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    repeat (5) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || mm_count != base) begin
      errors++;
      $display("FAIL start_stop: busy=%b done=%b issues=%0d, required 0/0/0", busy, done, mm_count - base);
    end
  endtask

  task automatic test_async_reset();
    int base, n;
    base = mm_count;
    plain_text = 8'd88; exponent = 8'd7; modulus = W'(M); mont_const = W'(MC);
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mm_count < base + 3 && n < 100) begin
      tick();
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({mm_start, mm_a, mm_b, mm_mod, result, done, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: mm_start=%b a=%0d b=%0d mod=%0d result=%0d done=%b busy=%b, required all 0",
               mm_start, mm_a, mm_b, mm_mod, result, done, busy);
    end
    tick();
    tick();
    rst = 1'b0;
    last_result = '0;
    tick();
    run_op("after_reset", 88, 7, -1, -1);
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_exp_zero();
    test_stop();
    test_snapshot();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
